bpred_pht_ctrl: RTL and testbench

- Controller and scheduler for a pattern history table (PHT) of 2-bit saturating branch counters.
- Shares the single-access table between two requesters:
  - fetch-side prediction lookups;
  - execute-side resolution updates, which are buffered in a small FIFO.
- Sequences a table-initialisation sweep after reset.
- Sits between the fetch stage and the branch-resolution logic.

---
 rtl/bpred_pht_ctrl.sv | 139 +++++++++++++
 tb/tb_bpred_pht_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bpred_pht_ctrl.sv
// bpred_pht_ctrl: scheduler for a single-port table of 2-bit branch counters.
// Sweeps every entry to weak not-taken after reset. After that it shares the
// one table access per cycle between fetch lookups and queued resolution updates.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   lk_valid/lk_ready      lookup handshake, with lk_pc the branch PC
//   pred_valid/pred_taken  registered prediction, one cycle after acceptance
//   up_valid/up_ready      update handshake, with up_pc and up_taken the outcome
//   init_done              high once the initialisation sweep has finished
module bpred_pht_ctrl #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned UPD_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lk_valid,
  output logic            lk_ready,
  input  logic [PC_W-1:0] lk_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [PC_W-1:0] up_pc,
  input  logic            up_taken,
  output logic            init_done
);

  localparam int unsigned PHT_N = 1 << IDX_W;
  localparam int unsigned PTR_W = $clog2(UPD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_t;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [IDX_W-1:0] sweep_ptr;
  logic [1:0]       pht [PHT_N];
  upd_t             fifo [UPD_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic             run;
  logic             full;
  logic             lk_fire;
  logic             push;
  logic             drain;
  upd_t             head_ent;
  logic [1:0]       head_cnt;
  logic [1:0]       upd_cnt;

  // PC bits outside the index field do not affect the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0],
                            up_pc[PC_W-1:IDX_W+2], up_pc[1:0]};

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign up_idx = up_pc[IDX_W+1:2];

  // Handshakes and table-port arbitration: full FIFO drains first, then lookup, then drain
  assign run      = (state == ST_RUN);
  assign full     = (count == CNT_W'(UPD_DEPTH));
  assign up_ready = run && !full;
  assign lk_ready = run && !full;
  assign lk_fire  = lk_valid && lk_ready;
  assign push     = up_valid && up_ready;
  assign drain    = run && (count != '0) && !lk_fire;

  assign head_ent = fifo[head];
  assign head_cnt = pht[head_ent.idx];

  // Saturating counter step for the head update
  always_comb begin
    upd_cnt = head_cnt;
    if (head_ent.taken) begin
      if (head_cnt != 2'd3) upd_cnt = head_cnt + 2'd1;
    end else if (head_cnt != 2'd0) begin
      upd_cnt = head_cnt - 2'd1;
    end
  end

  // Next state: leave INIT after the last entry has been written
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (sweep_ptr == IDX_W'(PHT_N - 1)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // Sweep pointer, FIFO bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_ptr  <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      if (!run)  sweep_ptr <= sweep_ptr + IDX_W'(1);
      if (push)  tail      <= tail + PTR_W'(1);
      if (drain) head      <= head + PTR_W'(1);
      count      <= count + CNT_W'(push) - CNT_W'(drain);
      pred_valid <= lk_fire;
      if (lk_fire) pred_taken <= pht[lk_idx][1];
      init_done  <= (state_nxt == ST_RUN);
    end
  end

  // Counter table: one write per cycle, sweep or drained update
  always_ff @(posedge clk) begin
    if (!run)       pht[sweep_ptr]    <= 2'd1;
    else if (drain) pht[head_ent.idx] <= upd_cnt;
  end

  // Update FIFO storage; contents are qualified by count
  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= '{idx: up_idx, taken: up_taken};
  end

endmodule

// File: tb/tb_bpred_pht_ctrl.sv
// tb_bpred_pht_ctrl: directed scenarios plus random traffic for bpred_pht_ctrl.
// A behavioural model tracks the counter table as an integer array and keeps
// pending updates in a queue. Every DUT output is compared against it each cycle.
module tb_bpred_pht_ctrl;

  logic        clk;
  logic        rst_n;
  logic        lk_valid;
  logic        lk_ready;
  logic [31:0] lk_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        up_valid;
  logic        up_ready;
  logic [31:0] up_pc;
  logic        up_taken;
  logic        init_done;

  bpred_pht_ctrl #(.PC_W(32), .IDX_W(4), .UPD_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc), .up_taken(up_taken),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int mdl [16];
  int q_idx [$];
  bit q_tk [$];
  int init_left;
  bit exp_pv;
  bit exp_pt;
  int stall_cnt;
  int pv_cnt;
  int acc_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model, cross the edge
  task automatic step(input bit lv, input logic [31:0] lpc, input bit uv,
                      input logic [31:0] upc, input bit ut);
    bit run, elr, eur, lf, uf, dr;
    int li, ui, c;
    run = (init_left == 0);
    elr = run && (q_idx.size() != 4);
    eur = run && (q_idx.size() < 4);
    lk_valid = lv; lk_pc = lpc; up_valid = uv; up_pc = upc; up_taken = ut;
    #1;
    check_eq("init_done", 32'(init_done), 32'(run));
    check_eq("lk_ready", 32'(lk_ready), 32'(elr));
    check_eq("up_ready", 32'(up_ready), 32'(eur));
    check_eq("pred_valid", 32'(pred_valid), 32'(exp_pv));
    if (exp_pv) check_eq("pred_taken", 32'(pred_taken), 32'(exp_pt));
    if (pred_valid) pv_cnt++;
    if (lv && !lk_ready) stall_cnt++;
    lf = lv && elr;
    uf = uv && eur;
    dr = run && (q_idx.size() > 0) && !lf;
    li = int'(lpc[5:2]);
    ui = int'(upc[5:2]);
    exp_pv = lf;
    if (lf) begin
      exp_pt = (mdl[li] >= 2);
      acc_cnt++;
    end
    if (dr) begin
      c = mdl[q_idx[0]];
      mdl[q_idx[0]] = q_tk[0] ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
      void'(q_idx.pop_front());
      void'(q_tk.pop_front());
    end
    if (uf) begin
      q_idx.push_back(ui);
      q_tk.push_back(ut);
    end
    if (!run) begin
      init_left--;
      if (init_left == 0) foreach (mdl[i]) mdl[i] = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Assert reset at a negedge, check the reset values, release two cycles later
  task automatic do_reset();
    rst_n = 1'b0;
    lk_valid = 1'b0; up_valid = 1'b0; lk_pc = '0; up_pc = '0; up_taken = 1'b0;
    #1;
    check_eq("rst_pred_valid", 32'(pred_valid), 32'h0);
    check_eq("rst_pred_taken", 32'(pred_taken), 32'h0);
    check_eq("rst_init_done", 32'(init_done), 32'h0);
    check_eq("rst_lk_ready", 32'(lk_ready), 32'h0);
    check_eq("rst_up_ready", 32'(up_ready), 32'h0);
    if (exp_pv) acc_cnt--;
    exp_pv = 1'b0;
    q_idx.delete();
    q_tk.delete();
    init_left = 16;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_sweep();
    idle(16);
    #1;
    check_eq("init_after_16", 32'(init_done), 32'h1);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; stall_cnt = 0; pv_cnt = 0; acc_cnt = 0;
    exp_pv = 1'b0; exp_pt = 1'b0; init_left = 16;
    foreach (mdl[i]) mdl[i] = 1;
    rst_n = 1'b0;
    lk_valid = 1'b0; up_valid = 1'b0; lk_pc = '0; up_pc = '0; up_taken = 1'b0;
    @(negedge clk);
    do_reset();
    check_sweep();

    // Every entry starts weak not-taken
    for (int i = 0; i < 16; i++) step(1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0);
    idle(1);

    // Two taken updates for PC 0x10, then four not-taken
    step(1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
    idle(3);
    step(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("ctr_sat_high", 32'(pred_taken), 32'h1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
    idle(3);
    step(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    idle(1);

    // Same-cycle push and lookup of 0x24: no forwarding
    step(1'b1, 32'h24, 1'b1, 32'h24, 1'b1);
    #1;
    check_eq("no_forward", 32'(pred_taken), 32'h0);
    @(negedge clk);
    idle(1);
    step(1'b1, 32'h24, 1'b0, 32'h0, 1'b0);
    idle(1);

    // Continuous lookups while four updates arrive back-to-back
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, (i < 4), $urandom, 1'($urandom));
    check_eq("stall_once", 32'(stall_cnt), 32'h1);

    // Fill the FIFO, then offer a push in the draining cycle
    step(1'b1, $urandom, 1'b1, $urandom, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h3c, 1'b1);
    #1;
    check_eq("count_dec", 32'(up_ready), 32'h1);
    @(negedge clk);
    idle(5);

    // Reset with three updates queued and a lookup in flight
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b1, $urandom, 1'($urandom));
    do_reset();
    check_sweep();

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), $urandom,
                ($urandom_range(0, 9) < 7), $urandom, 1'($urandom));
    end
    idle(20);
    check_eq("pulse_count", 32'(pv_cnt), 32'(acc_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
